// File: rtl/systolic_psum_writeback.sv
// Realigns the staircase-skewed psum columns of the systolic array so that one
// output row is written into every psum SRAM bank in the same cycle at one address.
module systolic_psum_writeback #(
  parameter int unsigned PE_COL   = 4,
  parameter int unsigned BIT_ADDR = 10,
  parameter int unsigned BIT_PSUM = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_Start,
  input  logic [BIT_ADDR-1:0]          i_Base_Addr,
  input  logic [BIT_ADDR-1:0]          i_Num_Rows,
  input  logic [BIT_PSUM*PE_COL-1:0]   i_Psum,
  input  logic [PE_COL-1:0]            i_Psum_Valid,
  output logic [BIT_ADDR*PE_COL-1:0]   o_Psram_Addr,
  output logic [BIT_PSUM*PE_COL-1:0]   o_Psram_Din,
  output logic [PE_COL-1:0]            o_Psram_En,
  output logic [PE_COL-1:0]            o_Psram_Wea,
  output logic                         o_Busy,
  output logic                         o_Done,
  output logic                         o_Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [PE_COL-1:0]          v_al;
  logic [BIT_PSUM*PE_COL-1:0] d_al;

  // Column c waits PE_COL-1-c cycles so all columns of a row line up with the last one.
  for (genvar c = 0; c < PE_COL; c++) begin : g_col
    localparam int unsigned DEPTH = PE_COL - 1 - c;
    if (DEPTH == 0) begin : g_pass
      assign v_al[c]                         = i_Psum_Valid[c];
      assign d_al[c*BIT_PSUM +: BIT_PSUM]    = i_Psum[c*BIT_PSUM +: BIT_PSUM];
    end else begin : g_dly
      logic [DEPTH-1:0]    vld_q;
      logic [BIT_PSUM-1:0] dat_q [DEPTH];

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          vld_q <= '0;
          for (int unsigned k = 0; k < DEPTH; k++) begin
            dat_q[k] <= '0;
          end
        end else begin
          vld_q[0] <= i_Psum_Valid[c];
          dat_q[0] <= i_Psum[c*BIT_PSUM +: BIT_PSUM];
          for (int unsigned k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end

      assign v_al[c]                      = vld_q[DEPTH-1];
      assign d_al[c*BIT_PSUM +: BIT_PSUM] = dat_q[DEPTH-1];
    end
  end

  state_e                     state_q, state_d;
  logic [BIT_ADDR-1:0]        addr_q, addr_d;
  logic [BIT_ADDR-1:0]        cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic                       en_q, en_d;
  logic [BIT_ADDR-1:0]        wr_addr_q, wr_addr_d;
  logic [BIT_PSUM*PE_COL-1:0] din_q, din_d;
  logic                       v_all, v_any;

  assign v_all = &v_al;
  assign v_any = |v_al;

  // Job sequencing and registered SRAM write request.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    en_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    din_d     = din_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          err_d = 1'b0;
          if (i_Num_Rows != '0) begin
            addr_d  = i_Base_Addr;
            cnt_d   = i_Num_Rows;
            state_d = S_RUN;
          end else begin
            // Empty job: pulse done right away; DONE must not pulse a second time.
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (v_all) begin
          en_d      = 1'b1;
          wr_addr_d = addr_q;
          din_d     = d_al;
          addr_d    = addr_q + BIT_ADDR'(1);
          cnt_d     = cnt_q - BIT_ADDR'(1);
          if (cnt_q == BIT_ADDR'(1)) begin
            state_d = S_DONE;
          end
        end else if (v_any) begin
          err_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d  = ~done_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      wr_addr_q <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
      wr_addr_q <= wr_addr_d;
      din_q     <= din_d;
    end
  end

  assign o_Psram_Addr = {PE_COL{wr_addr_q}};
  assign o_Psram_Din  = din_q;
  assign o_Psram_En   = {PE_COL{en_q}};
  assign o_Psram_Wea  = {PE_COL{en_q}};
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Err        = err_q;

endmodule

// File: tb/tb_systolic_psum_writeback.sv
// Bench for systolic_psum_writeback: directed jobs with random psum data and
// a cycle-indexed job-level reference model.
module tb_systolic_psum_writeback;

  localparam int PC = 4;
  localparam int BA = 10;
  localparam int BP = 32;
  localparam int NH = 4096;

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_Start;
  logic [BA-1:0]     i_Base_Addr;
  logic [BA-1:0]     i_Num_Rows;
  logic [BP*PC-1:0]  i_Psum;
  logic [PC-1:0]     i_Psum_Valid;
  logic [BA*PC-1:0]  o_Psram_Addr;
  logic [BP*PC-1:0]  o_Psram_Din;
  logic [PC-1:0]     o_Psram_En;
  logic [PC-1:0]     o_Psram_Wea;
  logic              o_Busy;
  logic              o_Done;
  logic              o_Err;

  systolic_psum_writeback #(.PE_COL(PC), .BIT_ADDR(BA), .BIT_PSUM(BP)) dut (
    .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Base_Addr(i_Base_Addr),
    .i_Num_Rows(i_Num_Rows), .i_Psum(i_Psum), .i_Psum_Valid(i_Psum_Valid),
    .o_Psram_Addr(o_Psram_Addr), .o_Psram_Din(o_Psram_Din), .o_Psram_En(o_Psram_En),
    .o_Psram_Wea(o_Psram_Wea), .o_Busy(o_Busy), .o_Done(o_Done), .o_Err(o_Err)
  );

  always #5 CLK = ~CLK;

  // Planned column traffic (pv/pd) and what was actually driven (hv/hd), per cycle.
  logic [PC-1:0]    pv [NH];
  logic [BP*PC-1:0] pd [NH];
  logic [PC-1:0]    hv [NH];
  logic [BP*PC-1:0] hd [NH];

  int cyc, hist_base, checks, errors;
  int wr_seen, done_seen;
  logic [BA-1:0]    last_addr;
  logic [BP*PC-1:0] last_din;

  // Reference job state and expected registered outputs.
  bit               job_on;
  int               rows_left, done_at, accept_from;
  logic [BA-1:0]    m_addr;
  logic             e_en, e_busy, e_done, e_err;
  logic [BA-1:0]    e_addr;
  logic [BP*PC-1:0] e_din;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    job_on = 0; rows_left = 0; m_addr = '0; done_at = -10; accept_from = 0;
    e_en = 0; e_addr = '0; e_din = '0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  // Inputs of cycle t -> expected outputs visible in cycle t+1.
  task automatic model_edge(input int t, input logic st, input logic [BA-1:0] base,
                            input logic [BA-1:0] rows);
    logic [PC-1:0]    v;
    logic [BP*PC-1:0] d;
    for (int c = 0; c < PC; c++) begin
      int k;
      k = t - (PC - 1 - c);
      if (k >= hist_base) begin
        v[c] = hv[k][c];
        d[c*BP +: BP] = hd[k][c*BP +: BP];
      end else begin
        v[c] = 1'b0;
        d[c*BP +: BP] = '0;
      end
    end
    e_en = 0;
    if (job_on) begin
      if (v == {PC{1'b1}}) begin
        e_en = 1; e_addr = m_addr; e_din = d;
        m_addr = m_addr + 1'b1;
        rows_left--;
        if (rows_left == 0) begin
          job_on = 0; done_at = t + 2; accept_from = t + 2;
        end
      end else if (v != '0) begin
        e_err = 1;
      end
    end else if (t >= accept_from && st) begin
      e_err = 0;
      if (rows == '0) begin
        done_at = t + 1; accept_from = t + 2;
      end else begin
        job_on = 1; m_addr = base; rows_left = int'(rows);
      end
    end
    e_busy = job_on;
    e_done = (done_at == t + 1);
  endtask

  task automatic launch_row(input int t0, input logic [BP-1:0] dat, input int late_col);
    for (int c = 0; c < PC; c++) begin
      int tt;
      tt = t0 + c + ((c == late_col) ? 1 : 0);
      pv[tt][c] = 1'b1;
      pd[tt][c*BP +: BP] = dat + BP'(c);
    end
  endtask

  task automatic step(input logic st, input logic [BA-1:0] base, input logic [BA-1:0] rows);
    logic [BP*PC-1:0] dd;
    logic [BA*PC-1:0] ea;
    for (int c = 0; c < PC; c++)
      dd[c*BP +: BP] = pv[cyc][c] ? pd[cyc][c*BP +: BP] : BP'($urandom);
    i_Start      = st;
    i_Base_Addr  = st ? base : BA'($urandom);
    i_Num_Rows   = st ? rows : BA'($urandom);
    i_Psum_Valid = pv[cyc];
    i_Psum       = dd;
    hv[cyc] = pv[cyc];
    hd[cyc] = dd;
    model_edge(cyc, st, base, rows);
    @(posedge CLK);
    #1;
    cyc++;
    for (int c = 0; c < PC; c++) ea[c*BA +: BA] = e_addr;
    chk("en",   128'(o_Psram_En),   128'({PC{e_en}}));
    chk("wea",  128'(o_Psram_Wea),  128'({PC{e_en}}));
    chk("addr", 128'(o_Psram_Addr), 128'(ea));
    chk("din",  128'(o_Psram_Din),  128'(e_din));
    chk("busy", 128'(o_Busy),       128'(e_busy));
    chk("done", 128'(o_Done),       128'(e_done));
    chk("err",  128'(o_Err),        128'(e_err));
    if (o_Psram_En[0]) begin
      wr_seen++;
      last_addr = o_Psram_Addr[BA-1:0];
      last_din  = o_Psram_Din;
    end
    if (o_Done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_en"},   128'(o_Psram_En),   128'(0));
    chk({tag, "_wea"},  128'(o_Psram_Wea),  128'(0));
    chk({tag, "_addr"}, 128'(o_Psram_Addr), 128'(0));
    chk({tag, "_din"},  128'(o_Psram_Din),  128'(0));
    chk({tag, "_busy"}, 128'(o_Busy),       128'(0));
    chk({tag, "_done"}, 128'(o_Done),       128'(0));
    chk({tag, "_err"},  128'(o_Err),        128'(0));
  endtask

  initial begin
    int s, w0, d0, tt, nrows, n;
    logic [BA-1:0] base;
    checks = 0; errors = 0; wr_seen = 0; done_seen = 0;
    last_addr = '0; last_din = '0;
    for (int i = 0; i < NH; i++) begin
      pv[i] = '0; pd[i] = '0; hv[i] = '0; hd[i] = '0;
    end
    RST = 1'b1;
    i_Start = 0; i_Base_Addr = '0; i_Num_Rows = '0; i_Psum = '0; i_Psum_Valid = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_outputs_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0; hist_base = 0;
    model_reset();

    // Single row, data 0x100+c.
    s = cyc; w0 = wr_seen; d0 = done_seen;
    launch_row(s + 2, 32'h100, -1);
    step(1'b1, 10'h010, 10'd1);
    idle(10);
    chk("single_writes", 128'(wr_seen - w0), 128'(1));
    chk("single_addr", 128'(last_addr), 128'(10'h010));
    chk("single_din", 128'(last_din), 128'h00000103_00000102_00000101_00000100);
    chk("single_done_cnt", 128'(done_seen - d0), 128'(1));

    // Streaming across the address wrap.
    s = cyc; w0 = wr_seen; d0 = done_seen;
    for (int r = 0; r < 4; r++) launch_row(s + 1 + r, BP'($urandom), -1);
    step(1'b1, 10'h3FE, 10'd4);
    idle(12);
    chk("wrap_writes", 128'(wr_seen - w0), 128'(4));
    chk("wrap_last_addr", 128'(last_addr), 128'(10'h001));
    chk("wrap_done_cnt", 128'(done_seen - d0), 128'(1));

    // Misaligned row: column 2 arrives one cycle late.
    s = cyc; w0 = wr_seen;
    launch_row(s + 1, BP'($urandom), -1);
    launch_row(s + 3, BP'($urandom), 2);
    launch_row(s + 6, BP'($urandom), -1);
    launch_row(s + 7, BP'($urandom), -1);
    step(1'b1, 10'h100, 10'd3);
    idle(14);
    chk("misalign_err", 128'(o_Err), 128'(1));
    chk("misalign_writes", 128'(wr_seen - w0), 128'(3));
    chk("misalign_last_addr", 128'(last_addr), 128'(10'h102));

    // Zero-row job recovers the error flag and writes nothing.
    w0 = wr_seen; d0 = done_seen;
    step(1'b1, 10'h2AA, 10'd0);
    idle(3);
    chk("zero_err_cleared", 128'(o_Err), 128'(0));
    chk("zero_writes", 128'(wr_seen - w0), 128'(0));
    chk("zero_done_cnt", 128'(done_seen - d0), 128'(1));

    // Start during RUN is ignored.
    s = cyc; w0 = wr_seen;
    launch_row(s + 1, BP'($urandom), -1);
    launch_row(s + 6, BP'($urandom), -1);
    step(1'b1, 10'h050, 10'd2);
    idle(2);
    step(1'b1, 10'h3AA, 10'd7);
    idle(12);
    chk("ignstart_writes", 128'(wr_seen - w0), 128'(2));
    chk("ignstart_last_addr", 128'(last_addr), 128'(10'h051));

    // Reset with rows in flight after two writes.
    s = cyc; w0 = wr_seen;
    for (int r = 0; r < 5; r++) launch_row(s + 1 + r, BP'($urandom), -1);
    step(1'b1, 10'h200, 10'd5);
    n = 0;
    while ((wr_seen - w0) < 2 && n < 40) begin
      idle(1);
      n++;
    end
    chk("rst_two_writes_seen", 128'(wr_seen - w0), 128'(2));
    #3;
    RST = 1'b1;
    i_Start = 0; i_Psum_Valid = '0;
    #1;
    chk_outputs_zero("midreset");
    @(posedge CLK); @(posedge CLK);
    cyc += 2;
    @(negedge CLK);
    RST = 1'b0;
    hist_base = cyc;
    model_reset();
    w0 = wr_seen;
    idle(10);
    chk("postreset_writes", 128'(wr_seen - w0), 128'(0));

    // Skewed traffic with no job armed.
    s = cyc; w0 = wr_seen;
    for (int r = 0; r < 6; r++)
      launch_row(s + 1 + 2*r, BP'($urandom), int'($urandom_range(0, 4)) - 1);
    idle(20);
    chk("idle_writes", 128'(wr_seen - w0), 128'(0));
    chk("idle_err", 128'(o_Err), 128'(0));

    // Random jobs with random row gaps.
    for (int j = 0; j < 4; j++) begin
      s = cyc; w0 = wr_seen; d0 = done_seen;
      nrows = int'($urandom_range(1, 6));
      base = BA'($urandom);
      tt = s + 1;
      for (int r = 0; r < nrows; r++) begin
        launch_row(tt, BP'($urandom), -1);
        tt += 1 + int'($urandom_range(0, 2));
      end
      step(1'b1, base, BA'(nrows));
      idle(tt - s + 8);
      chk("rand_writes", 128'(wr_seen - w0), 128'(nrows));
      chk("rand_last_addr", 128'(last_addr), 128'(BA'(base + BA'(nrows - 1))));
      chk("rand_done_cnt", 128'(done_seen - d0), 128'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
